// File: rtl/tdm_demux_1_to_4_if.sv
// Bus bundle between an upstream 4:1 TDM serialiser and the 1-to-4 demultiplexer.
// The master drives the serial slot stream; the slave returns the slot select and the frame results.
interface tdm_demux_1_to_4_if;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic [1:0] sel;
  logic [3:0] x;
  logic       x_valid;
  logic       frame_err;
  logic       par_slot;
  logic       parity_err;

  modport master (
    output din, din_valid, sync,
    input  sel, x, x_valid, frame_err, par_slot, parity_err
  );

  modport slave (
    input  din, din_valid, sync,
    output sel, x, x_valid, frame_err, par_slot, parity_err
  );
endinterface

// File: rtl/tdm_demux_1_to_4.sv
// Serial TDM to 4-bit parallel demultiplexer, with frames delimited by sync.
// Defining TDM_DEMUX_PARITY_EN adds a fifth, even-parity slot to every frame.
module tdm_demux_1_to_4 (
  input  logic                  clk,
  input  logic                  rst,
  tdm_demux_1_to_4_if.slave     bus
);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 2;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [3:0]       slot_buf, slot_buf_nxt;
  logic [3:0]       x_reg, x_nxt;
  logic             x_valid_reg, x_valid_nxt;
  logic             frame_err_reg, frame_err_nxt;
  logic             parity_err_reg, parity_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      counter        <= '0;
      slot_buf       <= '0;
      x_reg          <= '0;
      x_valid_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state          <= state_nxt;
      counter        <= counter_nxt;
      slot_buf       <= slot_buf_nxt;
      x_reg          <= x_nxt;
      x_valid_reg    <= x_valid_nxt;
      frame_err_reg  <= frame_err_nxt;
      parity_err_reg <= parity_err_nxt;
    end
  end

  // A sync always restarts the frame at slot 0; it is only an error when a frame was in progress.
  always_comb begin
    state_nxt      = state;
    counter_nxt    = counter;
    slot_buf_nxt   = slot_buf;
    x_nxt          = x_reg;
    x_valid_nxt    = 1'b0;
    frame_err_nxt  = 1'b0;
    parity_err_nxt = 1'b0;

    if (bus.din_valid) begin
      if (bus.sync) begin
        frame_err_nxt = (state == RECV);
        slot_buf_nxt  = {3'b000, bus.din};
        counter_nxt   = CNT_W'(1);
        state_nxt     = RECV;
      end else if (state == RECV) begin
`ifdef TDM_DEMUX_PARITY_EN
        if (counter == 3'd4) begin
          if ((bus.din ^ (^slot_buf)) == 1'b0) begin
            x_nxt       = slot_buf;
            x_valid_nxt = 1'b1;
          end else begin
            parity_err_nxt = 1'b1;
          end
          counter_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          slot_buf_nxt[counter[1:0]] = bus.din;
          counter_nxt                = counter + 3'd1;
        end
`else
        if (counter == 2'd3) begin
          x_nxt       = {bus.din, slot_buf[2:0]};
          x_valid_nxt = 1'b1;
          counter_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          slot_buf_nxt[counter] = bus.din;
          counter_nxt           = counter + 2'd1;
        end
`endif
      end
    end
  end

  // In the parity slot the counter is 4, so its low bits already present sel = 00 upstream.
  assign bus.sel       = counter[1:0];
  assign bus.x         = x_reg;
  assign bus.x_valid   = x_valid_reg;
  assign bus.frame_err = frame_err_reg;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_slot   = (counter == 3'd4);
  assign bus.parity_err = parity_err_reg;
`else
  assign bus.par_slot   = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = parity_err_reg;

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Directed self-checking bench for tdm_demux_1_to_4; flags are packed as
// {x_valid, frame_err, par_slot, parity_err}. Define TDM_DEMUX_PARITY_EN to exercise the parity build.
module tb_tdm_demux_1_to_4;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  tdm_demux_1_to_4_if bus ();

  tdm_demux_1_to_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic s, input logic d);
    bus.din_valid = v;
    bus.sync      = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_sel,
                             input logic [3:0] exp_x, input logic [3:0] exp_flags);
    logic [9:0] observed;
    logic [9:0] expected;
    observed = {bus.sel, bus.x, bus.x_valid, bus.frame_err, bus.par_slot, bus.parity_err};
    expected = {exp_sel, exp_x, exp_flags};
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed sel/x/flags=%b/%b/%b expected=%b/%b/%b", tag,
             observed[9:8], observed[7:4], observed[3:0],
             expected[9:8], expected[7:4], expected[3:0]);
    end
  endtask

  // Final data slot plus, in the parity build, the parity slot; prev_x is what x must hold before completion.
  task automatic finishFrame(input string tag, input logic d3, input logic par,
                             input logic [3:0] prev_x, input logic [3:0] exp_x);
    applyStimulus(1'b1, 1'b0, d3);
`ifdef TDM_DEMUX_PARITY_EN
    checkOutput({tag, "_parslot"}, 2'b00, prev_x, 4'b0010);
    applyStimulus(1'b1, 1'b0, par);
`else
    if (par) begin end
    if (prev_x != exp_x) begin end
`endif
    checkOutput({tag, "_done"}, 2'b00, exp_x, 4'b1000);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.din       = 1'b0;

    // Reset with random traffic on the inputs
    for (int i = 0; i < 2; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkOutput("reset", 2'b00, 4'b0000, 4'b0000);
    rst = 1'b0;

    // Consecutive frame 1,0,1,1 -> 1101
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("f1_s0", 2'b01, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("f1_s1", 2'b10, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("f1_s2", 2'b11, 4'b0000, 4'b0000);
    finishFrame("f1", 1'b1, 1'b1, 4'b0000, 4'b1101);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("f1_pulse_end", 2'b00, 4'b1101, 4'b0000);

    // Frame 0,1,1,0 with three invalid cycles between bits -> 0110
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("f2_s0", 2'b01, 4'b1101, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("f2_gap0", 2'b01, 4'b1101, 4'b0000);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("f2_s1", 2'b10, 4'b1101, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("f2_gap1", 2'b10, 4'b1101, 4'b0000);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("f2_s2", 2'b11, 4'b1101, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("f2_gap2", 2'b11, 4'b1101, 4'b0000);
    end
    finishFrame("f2", 1'b0, 1'b0, 4'b1101, 4'b0110);

    // Aborted frame sync,1,0 then sync,0,0,0,1 -> frame_err once, x=1000
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("f3a_s0", 2'b01, 4'b0110, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("f3a_s1", 2'b10, 4'b0110, 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("f3_resync", 2'b01, 4'b0110, 4'b0100);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("f3_s1", 2'b10, 4'b0110, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("f3_s2", 2'b11, 4'b0110, 4'b0000);
    finishFrame("f3", 1'b1, 1'b1, 4'b0110, 4'b1000);

    // Valid bits without sync while idle are discarded
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("idle_nosync", 2'b00, 4'b1000, 4'b0000);
    end

    // Back-to-back frames 0,1,0,0 then 1,1,1,1 with no idle cycle between
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("f4_s2", 2'b11, 4'b1000, 4'b0000);
    finishFrame("f4", 1'b0, 1'b1, 4'b1000, 4'b0010);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("f5_s0", 2'b01, 4'b0010, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    finishFrame("f5", 1'b1, 1'b0, 4'b0010, 4'b1111);

    // Reset mid-frame has priority over a concurrent sync and raises no error
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("f6_s1", 2'b10, 4'b1111, 4'b0000);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("mid_reset", 2'b00, 4'b0000, 4'b0000);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset", 2'b00, 4'b0000, 4'b0000);

`ifdef TDM_DEMUX_PARITY_EN
    // Good parity: data 1,1,0,0 parity 0 -> 0011
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    finishFrame("par_ok", 1'b0, 1'b0, 4'b0000, 4'b0011);
    // Bad parity: data 1,0,0,0 parity 0 -> parity_err, x holds 0011
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("par_bad_slot", 2'b00, 4'b0011, 4'b0010);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("par_bad_err", 2'b00, 4'b0011, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("par_bad_end", 2'b00, 4'b0011, 4'b0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_to_4.md
TDM_DEMUX_1_TO_4 -- requirements
Module: tdm_demux_1_to_4

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: din  input  1  serial TDM data bit for the current slot.
REQ-004 SHALL: din_valid  input  1  din is meaningful this cycle; all other cycles are ignored.
REQ-005 SHALL: sync  input  1  qualified by din_valid; marks the current bit as slot 0 of a frame.
REQ-006 SHALL: sel  output  2  index of the slot expected next; directly drives an upstream 4:1 mux select.
REQ-007 SHALL: x  output  4  last completed frame; x[i] = bit received in slot i.
REQ-008 SHALL: x_valid  output  1  one-cycle pulse when x is updated.
REQ-009 SHALL: frame_err  output  1  one-cycle pulse on sync arriving mid-frame.
REQ-010 SHALL: par_slot  output  1  high while the parity slot is expected; constant 0 when parity is compiled out.
REQ-011 SHALL: parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-012 SHALL: FSM with two states:
- IDLE: wait for frame start.
- RECV: collect slots.
REQ-013 SHALL: internal slot counter; sel = counter[1:0]; counter = 0 in IDLE.
REQ-014 SHALL: in IDLE, din_valid=1 with sync=1 stores din as slot 0, sets counter=1 and enters RECV.
REQ-015 SHALL: in IDLE, din_valid=1 with sync=0 is discarded; no output changes.
REQ-016 SHALL: in RECV, din_valid=1 with sync=0 stores din into slot[counter] and increments counter.
REQ-017 SHALL: in RECV, din_valid=1 with sync=1:
- pulse frame_err next cycle;
- discard the partial frame;
- store din as slot 0, set counter=1, remain in RECV.
REQ-018 SHALL: in any state, din_valid=0 holds the FSM, counter and slot buffer unchanged, with no timeout.
REQ-019 SHALL: on the final data slot (slot 3, parity compiled out):
- x <= {din, buf[2:0]};
- x_valid pulses for exactly the cycle after that edge;
- FSM returns to IDLE, counter=0.
REQ-020 SHALL: each new frame requires sync; there is no free-running wrap into the next frame.
REQ-021 SHALL: x holds its value between completions; an aborted or erroneous frame never alters x.
REQ-022 SHALL: latency, final slot sample to x/x_valid = 1 clk; a full frame needs 4 din_valid cycles (5 with parity).
REQ-023 SHALL: back-to-back frames are supported: sync on the cycle right after completion starts a new frame with no lost cycle.

Reset
REQ-024 SHALL: when rst=1 at a clock edge:
- FSM=IDLE, counter=0, slot buffer=0;
- x=4'b0000, sel=2'b00;
- x_valid, frame_err, par_slot, parity_err = 0.
REQ-025 SHALL: rst has priority over all other inputs; rst mid-frame discards the partial frame with no error pulse.

Configuration
REQ-026 SHALL: macro TDM_DEMUX_PARITY_EN selects parity support.
REQ-027 SHALL: with TDM_DEMUX_PARITY_EN defined:
- each frame has a fifth slot (counter=4) carrying an even-parity bit;
- sel = 2'b00 and par_slot = 1 while that slot is expected;
- if din ^ ^buf[3:0] == 0: update x and pulse x_valid;
- otherwise pulse parity_err and leave x unchanged;
- either way return to IDLE.
REQ-028 SHALL: with TDM_DEMUX_PARITY_EN undefined:
- frame is 4 slots;
- par_slot and parity_err are tied to 0;
- no parity logic is synthesized.

Verification
REQ-029 SHALL: rst=1 for 2 clk with random din/din_valid -> x=0000, sel=00, all pulses 0.
REQ-030 SHALL: sync+bits 1,0,1,1 (slots 0..3) on consecutive valid cycles -> x=4'b1101, single x_valid pulse 1 clk after slot 3, sel stepping 00,01,10,11,00.
REQ-031 SHALL: frame 0,1 with gaps of 3 invalid cycles between bits, then 1,0 -> x=4'b0110, counter frozen during gaps.
REQ-032 SHALL: sync,1,0 then sync,0,0,0,1 -> frame_err pulse once, x=4'b1000, no x_valid for the aborted frame.
REQ-033 SHALL: din_valid without sync while IDLE (3 bits) -> x unchanged, sel=00, no pulses.
REQ-034 SHALL (TDM_DEMUX_PARITY_EN defined):
- data 1,1,0,0 with parity 0 -> x=4'b0011, x_valid;
- data 1,0,0,0 with parity 0 -> parity_err pulse, x stays 4'b0011.
